// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : mem_arb_pkg
//  Purpose   : Shared types and constants for the memory port arbiter:
//              FSM state encodings and grant-select values.
//  Revision  : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

  // Arbiter FSM states, explicitly 2 bits wide
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2,
    IDROP = 2'd3
  } arb_state_t;

  // Grant select: which requester owns the next memory transaction
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Interface : mem_port_arbiter_if
//  Purpose   : Bundles the fetch port, data port, shared memory port and the
//              busy indication of the memory port arbiter.
//              master - arbiter view (drives acks, read data, memory command)
//              slave  - environment view (pipeline requesters and memory)
//  Revision  : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  // Instruction-fetch port
  logic            i_req;
  logic [AW-1:0]   i_addr;
  logic            i_cancel;
  logic            i_ack;
  logic [DW-1:0]   i_rdata;

  // Data-memory port
  logic            d_req;
  logic [DW/8-1:0] d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic            d_ack;
  logic [DW-1:0]   d_rdata;

  // Shared memory port
  logic            m_req;
  logic [DW/8-1:0] m_we;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic            m_ready;
  logic [DW-1:0]   m_rdata;

  // Status
  logic            busy;

  modport master (
    input  i_req, i_addr, i_cancel,
    output i_ack, i_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_ack, d_rdata,
    output m_req, m_we, m_addr, m_wdata,
    input  m_ready, m_rdata,
    output busy
  );

  modport slave (
    output i_req, i_addr, i_cancel,
    input  i_ack, i_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_ack, d_rdata,
    input  m_req, m_we, m_addr, m_wdata,
    output m_ready, m_rdata,
    input  busy
  );

endinterface : mem_port_arbiter_if
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module    : mem_port_arbiter
//  Purpose   : Shares one single-ported, variable-latency memory between the
//              instruction-fetch and data-memory ports. One transaction in
//              flight; completion is a one-cycle ack to the owning port.
//              A fetch cancelled while in flight is drained silently (IDROP).
//  Options   : ARB_FAIR_EN - when defined, a fairness flag lets a starved
//              fetch win the next conflict after data won the previous one.
//              Undefined: strict data priority.
//  Revision  : 1.0  initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);

  arb_state_t      r_state;
  arb_state_t      w_nextState;

  logic            r_mReq;
  logic [DW/8-1:0] r_mWe;
  logic [AW-1:0]   r_mAddr;
  logic [DW-1:0]   r_mWdata;

  logic            w_fetchReq;
  logic            w_anyReq;
  logic            w_grant;
  logic            w_launch;

`ifdef ARB_FAIR_EN
  logic            r_fairFlag;
`endif

  // Arbitration: a cancelled fetch does not compete; data wins conflicts
  // unless the fairness flag says fetch is owed a turn
  always_comb begin
    w_fetchReq = bus.i_req & ~bus.i_cancel;
    w_anyReq   = w_fetchReq | bus.d_req;
    w_grant    = bus.d_req ? GNT_D : GNT_I;
`ifdef ARB_FAIR_EN
    if (bus.d_req && w_fetchReq && r_fairFlag) begin
      w_grant = GNT_I;
    end
`endif
    w_launch   = (r_state == IDLE) && w_anyReq;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_anyReq) begin
          w_nextState = (w_grant == GNT_D) ? DBUSY : IBUSY;
        end
      end
      IBUSY: begin
        // Completion wins over cancel: the fetch is simply not acknowledged
        if (bus.m_ready) begin
          w_nextState = IDLE;
        end else if (bus.i_cancel) begin
          w_nextState = IDROP;
        end
      end
      DBUSY, IDROP: begin
        if (bus.m_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Output logic: single-cycle acks gated by the completing state
  always_comb begin
    bus.i_ack = 1'b0;
    bus.d_ack = 1'b0;
    bus.busy  = (r_state != IDLE);
    case (r_state)
      IBUSY:   bus.i_ack = bus.m_ready & ~bus.i_cancel;
      DBUSY:   bus.d_ack = bus.m_ready;
      default: ;
    endcase
  end

  // Memory command registers: latched at launch, held until completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mReq   <= 1'b0;
      r_mWe    <= '0;
      r_mAddr  <= '0;
      r_mWdata <= '0;
    end else begin
      r_mReq <= (w_nextState != IDLE);
      if (w_launch) begin
        if (w_grant == GNT_D) begin
          r_mWe    <= bus.d_we;
          r_mAddr  <= bus.d_addr;
          r_mWdata <= bus.d_wdata;
        end else begin
          r_mWe    <= '0;
          r_mAddr  <= bus.i_addr;
          r_mWdata <= '0;
        end
      end
    end
  end

`ifdef ARB_FAIR_EN
  // Fairness flag: remembers who won the last fetch/data conflict
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fairFlag <= 1'b0;
    end else if (w_launch && w_fetchReq && bus.d_req) begin
      r_fairFlag <= (w_grant == GNT_D);
    end
  end
`endif

  assign bus.m_req   = r_mReq;
  assign bus.m_we    = r_mWe;
  assign bus.m_addr  = r_mAddr;
  assign bus.m_wdata = r_mWdata;

  // Read data is a straight pass-through; only meaningful in the ack cycle
  assign bus.i_rdata = bus.m_rdata;
  assign bus.d_rdata = bus.m_rdata;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module    : tb_mem_port_arbiter
//  Purpose   : Self-checking bench for mem_port_arbiter: directed scenarios
//              plus a randomized run against a transaction-level model.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   passes;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge (input drive point)
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.i_req = 1'b0; bus.i_addr = '0; bus.i_cancel = 1'b0;
    bus.d_req = 1'b0; bus.d_we = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_ready = 1'b0; bus.m_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clearInputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.m_req !== 1'b0) $display("FAIL reset_mreq: got %b want 0", bus.m_req); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passes++;
    checks++; if ({bus.m_we, bus.m_addr, bus.m_wdata} !== 68'h0) $display("FAIL reset_cmd: got %h want 0", {bus.m_we, bus.m_addr, bus.m_wdata}); else passes++;
    checks++; if ({bus.i_ack, bus.d_ack} !== 2'b00) $display("FAIL reset_acks: got %b want 00", {bus.i_ack, bus.d_ack}); else passes++;
    nextCycle();
    rst = 1'b1;
  endtask

  task automatic test_single_fetch();
    int reqCycles = 0;
    int ackCount = 0;
    nextCycle();
    bus.i_req = 1'b1; bus.i_addr = 32'h0040_0000;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) $display("FAIL fetch_idle_busy: got %b want 0", bus.busy); else passes++;
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      bus.m_ready = (c == 2);
      bus.m_rdata = (c == 2) ? 32'h8C08_0004 : 32'h0;
      @(negedge clk);
      if (bus.m_req === 1'b1) reqCycles++;
      if (c == 0) begin
        checks++; if ({bus.m_addr, bus.m_we} !== {32'h0040_0000, 4'h0}) $display("FAIL fetch_cmd: got %h want %h", {bus.m_addr, bus.m_we}, {32'h0040_0000, 4'h0}); else passes++;
      end
      if (bus.i_ack === 1'b1) begin
        ackCount++;
        checks++; if (bus.i_rdata !== 32'h8C08_0004) $display("FAIL fetch_rdata: got %h want 8c080004", bus.i_rdata); else passes++;
      end
    end
    nextCycle();
    bus.i_req = 1'b0; bus.m_ready = 1'b0;
    @(negedge clk);
    checks++; if (reqCycles !== 3) $display("FAIL fetch_mreq_cycles: got %0d want 3", reqCycles); else passes++;
    checks++; if (ackCount !== 1) $display("FAIL fetch_ack_pulses: got %0d want 1", ackCount); else passes++;
    checks++; if ({bus.busy, bus.m_req, bus.i_ack} !== 3'b000) $display("FAIL fetch_after: got %b want 000", {bus.busy, bus.m_req, bus.i_ack}); else passes++;
  endtask

  task automatic test_store();
    nextCycle();
    bus.d_req = 1'b1; bus.d_we = 4'b1111; bus.d_addr = 32'h1001_0000; bus.d_wdata = 32'hDEAD_BEEF;
    nextCycle();
    bus.m_ready = 1'b1;
    @(negedge clk);
    checks++; if ({bus.m_req, bus.m_we} !== 5'b1_1111) $display("FAIL store_mwe: got %b want 11111", {bus.m_req, bus.m_we}); else passes++;
    checks++; if ({bus.m_addr, bus.m_wdata} !== {32'h1001_0000, 32'hDEAD_BEEF}) $display("FAIL store_cmd: got %h want 10010000deadbeef", {bus.m_addr, bus.m_wdata}); else passes++;
    checks++; if ({bus.d_ack, bus.i_ack} !== 2'b10) $display("FAIL store_ack: got %b want 10", {bus.d_ack, bus.i_ack}); else passes++;
    nextCycle();
    bus.d_req = 1'b0; bus.d_we = '0; bus.m_ready = 1'b0;
    @(negedge clk);
    checks++; if ({bus.d_ack, bus.busy, bus.m_req} !== 3'b000) $display("FAIL store_after: got %b want 000", {bus.d_ack, bus.busy, bus.m_req}); else passes++;
  endtask

  // Both ports request continuously for four accesses each
  task automatic test_simultaneous();
    int dDone = 0;
    int iDone = 0;
    int n = 0;
    bit expD;
    for (int c = 0; c < 40 && (dDone < 4 || iDone < 4); c++) begin
      nextCycle();
      bus.d_req = (dDone < 4); bus.d_we = '0; bus.d_addr = 32'h1000_0000 + 32'(dDone * 4);
      bus.i_req = (iDone < 4); bus.i_addr = 32'h0040_0000 + 32'(iDone * 4);
      bus.m_ready = bus.m_req;
      bus.m_rdata = bus.m_addr ^ 32'hA5A5_A5A5;
      @(negedge clk);
`ifdef ARB_FAIR_EN
      expD = (n % 2 == 0);
`else
      expD = (n < 4);
`endif
      checks++; if ((bus.i_ack & bus.d_ack) !== 1'b0) $display("FAIL sim_both_acks: got 1 want 0"); else passes++;
      if (bus.d_ack === 1'b1) begin
        checks++; if (expD !== 1'b1) $display("FAIL sim_order: access %0d got D want I", n); else passes++;
        checks++; if (bus.d_rdata !== ((32'h1000_0000 + 32'(dDone * 4)) ^ 32'hA5A5_A5A5)) $display("FAIL sim_daddr: got %h want %h", bus.d_rdata ^ 32'hA5A5_A5A5, 32'h1000_0000 + 32'(dDone * 4)); else passes++;
        dDone++; n++;
      end else if (bus.i_ack === 1'b1) begin
        checks++; if (expD !== 1'b0) $display("FAIL sim_order: access %0d got I want D", n); else passes++;
        checks++; if (bus.i_rdata !== ((32'h0040_0000 + 32'(iDone * 4)) ^ 32'hA5A5_A5A5)) $display("FAIL sim_iaddr: got %h want %h", bus.i_rdata ^ 32'hA5A5_A5A5, 32'h0040_0000 + 32'(iDone * 4)); else passes++;
        iDone++; n++;
      end
    end
    checks++; if ({dDone, iDone} !== {32'd4, 32'd4}) $display("FAIL sim_timeout: got d=%0d i=%0d want 4/4", dDone, iDone); else passes++;
    nextCycle();
    clearInputs();
  endtask

  task automatic test_cancel_mid();
    int reqHeld = 0;
    int iSeen = 0;
    int dSeen = 0;
    nextCycle();
    bus.i_req = 1'b1; bus.i_addr = 32'h0040_0100;
    nextCycle();
    @(negedge clk);
    checks++; if ({bus.m_req, bus.m_addr} !== {1'b1, 32'h0040_0100}) $display("FAIL cancel_issue: got %h want 100400100", {bus.m_req, bus.m_addr}); else passes++;
    nextCycle();
    bus.i_cancel = 1'b1; bus.i_req = 1'b0;
    bus.d_req = 1'b1; bus.d_we = '0; bus.d_addr = 32'h1001_0040;
    @(negedge clk);
    checks++; if ({bus.i_ack, bus.busy} !== 2'b01) $display("FAIL cancel_cycle: got %b want 01", {bus.i_ack, bus.busy}); else passes++;
    for (int k = 3; k <= 5; k++) begin
      nextCycle();
      bus.i_cancel = 1'b0;
      bus.m_ready = (k == 5);
      bus.m_rdata = 32'h0BAD_0BAD;
      @(negedge clk);
      if (bus.m_req === 1'b1 && bus.m_addr === 32'h0040_0100) reqHeld++;
      if (bus.i_ack === 1'b1) iSeen++;
      if (bus.d_ack === 1'b1) dSeen++;
    end
    checks++; if (reqHeld !== 3) $display("FAIL cancel_mreq_held: got %0d want 3", reqHeld); else passes++;
    checks++; if ({iSeen, dSeen} !== 64'd0) $display("FAIL cancel_no_ack: got i=%0d d=%0d want 0/0", iSeen, dSeen); else passes++;
    nextCycle();
    bus.m_ready = 1'b0;
    @(negedge clk);
    checks++; if ({bus.m_req, bus.busy} !== 2'b00) $display("FAIL cancel_idle: got %b want 00", {bus.m_req, bus.busy}); else passes++;
    nextCycle();
    bus.m_ready = 1'b1; bus.m_rdata = 32'h1234_5678;
    @(negedge clk);
    checks++; if ({bus.m_req, bus.m_addr} !== {1'b1, 32'h1001_0040}) $display("FAIL cancel_dgrant: got %h want 110010040", {bus.m_req, bus.m_addr}); else passes++;
    checks++; if ({bus.d_ack, bus.d_rdata} !== {1'b1, 32'h1234_5678}) $display("FAIL cancel_dack: got %h want 112345678", {bus.d_ack, bus.d_rdata}); else passes++;
    nextCycle();
    clearInputs();
  endtask

  task automatic test_cancel_same_cycle();
    nextCycle();
    bus.i_req = 1'b1; bus.i_addr = 32'h0040_0200;
    nextCycle();
    bus.m_ready = 1'b1; bus.i_cancel = 1'b1; bus.m_rdata = 32'h5555_AAAA;
    @(negedge clk);
    checks++; if ({bus.i_ack, bus.d_ack} !== 2'b00) $display("FAIL cancel_same_ack: got %b want 00", {bus.i_ack, bus.d_ack}); else passes++;
    nextCycle();
    clearInputs();
    @(negedge clk);
    checks++; if ({bus.busy, bus.m_req} !== 2'b00) $display("FAIL cancel_same_idle: got %b want 00", {bus.busy, bus.m_req}); else passes++;
  endtask

  task automatic test_reset_mid();
    nextCycle();
    bus.d_req = 1'b1; bus.d_we = 4'b0011; bus.d_addr = 32'h1001_0080; bus.d_wdata = 32'hCAFE_F00D;
    nextCycle();
    bus.m_ready = 1'b1;
    #2;
    checks++; if (bus.d_ack !== 1'b1) $display("FAIL rstmid_pre_ack: got %b want 1", bus.d_ack); else passes++;
    rst = 1'b0;
    #1;
    checks++; if ({bus.m_req, bus.busy, bus.d_ack, bus.i_ack} !== 4'b0000) $display("FAIL rstmid_ctrl: got %b want 0000", {bus.m_req, bus.busy, bus.d_ack, bus.i_ack}); else passes++;
    checks++; if ({bus.m_we, bus.m_addr, bus.m_wdata} !== 68'h0) $display("FAIL rstmid_cmd: got %h want 0", {bus.m_we, bus.m_addr, bus.m_wdata}); else passes++;
    clearInputs();
    nextCycle();
    rst = 1'b1;
    nextCycle();
    bus.i_req = 1'b1; bus.i_addr = 32'h0040_0300;
    nextCycle();
    bus.m_ready = 1'b1; bus.m_rdata = 32'h2402_0001;
    @(negedge clk);
    checks++; if ({bus.m_addr, bus.i_ack, bus.i_rdata} !== {32'h0040_0300, 1'b1, 32'h2402_0001}) $display("FAIL rstmid_fetch: got %h want %h", {bus.m_addr, bus.i_ack, bus.i_rdata}, {32'h0040_0300, 1'b1, 32'h2402_0001}); else passes++;
    nextCycle();
    clearInputs();
  endtask

  // Randomized traffic checked against a transaction-level model: the memory
  // serves one command at a time, the winner follows the priority rules, and
  // a fetch cancelled at any point of its life is never acknowledged.
  task automatic test_random();
    bit outst = 0, ownerD = 0, cancelled = 0, fairFlag = 0;
    bit dAct = 0, iAct = 0, fe, de, expIAck, expDAck;
    logic [31:0] cmdAddr = '0, cmdWdata = '0;
    logic [3:0]  cmdWe = '0;
    int acksD = 0, acksI = 0;
    clearInputs();
    for (int c = 0; c < 600; c++) begin
      nextCycle();
      bus.i_cancel = 1'b0;
      if (!dAct && ($urandom % 3 == 0)) begin
        dAct = 1; bus.d_addr = $urandom; bus.d_wdata = $urandom;
        bus.d_we = ($urandom % 2 == 0) ? 4'($urandom) : 4'h0;
      end
      bus.d_req = dAct;
      if (!iAct && ($urandom % 2 == 0)) begin
        iAct = 1; bus.i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (iAct && ($urandom % 10 == 0)) begin
        bus.i_cancel = 1'b1; iAct = 0;
      end else if (!iAct && ($urandom % 20 == 0)) begin
        bus.i_cancel = 1'b1;
      end
      bus.i_req = iAct;
      bus.m_ready = outst && ($urandom % 3 == 0);
      bus.m_rdata = $urandom;
      @(negedge clk);
      expIAck = outst && !ownerD && bus.m_ready && !cancelled && !bus.i_cancel;
      expDAck = outst && ownerD && bus.m_ready;
      checks++; if ({bus.m_req, bus.busy} !== {outst, outst}) $display("FAIL rnd_mreq_busy c%0d: got %b want %b", c, {bus.m_req, bus.busy}, {outst, outst}); else passes++;
      if (outst) begin
        checks++; if ({bus.m_addr, bus.m_we} !== {cmdAddr, cmdWe}) $display("FAIL rnd_cmd c%0d: got %h want %h", c, {bus.m_addr, bus.m_we}, {cmdAddr, cmdWe}); else passes++;
        if (ownerD && cmdWe != 4'h0) begin
          checks++; if (bus.m_wdata !== cmdWdata) $display("FAIL rnd_wdata c%0d: got %h want %h", c, bus.m_wdata, cmdWdata); else passes++;
        end
      end
      checks++; if ({bus.i_ack, bus.d_ack} !== {expIAck, expDAck}) $display("FAIL rnd_acks c%0d: got %b want %b", c, {bus.i_ack, bus.d_ack}, {expIAck, expDAck}); else passes++;
      if (expIAck) begin
        checks++; if (bus.i_rdata !== bus.m_rdata) $display("FAIL rnd_irdata c%0d: got %h want %h", c, bus.i_rdata, bus.m_rdata); else passes++;
      end
      if (expDAck) begin
        checks++; if (bus.d_rdata !== bus.m_rdata) $display("FAIL rnd_drdata c%0d: got %h want %h", c, bus.d_rdata, bus.m_rdata); else passes++;
      end
      if (bus.i_ack === 1'b1) acksI++;
      if (bus.d_ack === 1'b1) acksD++;
      if (expDAck) dAct = 0;
      if (expIAck) iAct = 0;
      if (outst) begin
        if (!ownerD && bus.i_cancel) cancelled = 1;
        if (bus.m_ready) outst = 0;
      end else begin
        fe = bus.i_req && !bus.i_cancel;
        de = bus.d_req;
        if (fe || de) begin
`ifdef ARB_FAIR_EN
          ownerD = de && !(fe && fairFlag);
          if (fe && de) fairFlag = ownerD;
`else
          ownerD = de;
`endif
          outst = 1; cancelled = 0;
          cmdAddr  = ownerD ? bus.d_addr : bus.i_addr;
          cmdWe    = ownerD ? bus.d_we : 4'h0;
          cmdWdata = bus.d_wdata;
        end
      end
    end
    checks++; if (acksI == 0 || acksD == 0) $display("FAIL rnd_progress: got i=%0d d=%0d want both nonzero", acksI, acksD); else passes++;
    nextCycle();
    clearInputs();
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_single_fetch();
    test_store();
    test_simultaneous();
    test_cancel_mid();
    test_cancel_same_cycle();
    test_reset_mid();
    test_random();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
